// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with a pending-write scoreboard.
//
// Two combinational read ports can forward same-cycle write data. There are
// two synchronous write ports, and port 1 wins an address collision.
// The scoreboard holds one pending bit per register. Reserve sets a bit and
// writeback clears it. The per-read-port Busy flags feed the stall unit.
//
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   ReadRegister1/2 -> ReadData1/2     combinational read ports
//   WriteRegister0/1, WriteData0/1,
//   RegWrite0/1                        synchronous write ports
//   Reserve, ReserveRegister           mark a destination pending
//   Busy1/2                            read address has a pending write
//   PendCount                          registered count of pending bits
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    input  logic [ADDR_W-1:0] WriteRegister0,
    input  logic [DATA_W-1:0] WriteData0,
    input  logic              RegWrite0,
    input  logic [ADDR_W-1:0] WriteRegister1,
    input  logic [DATA_W-1:0] WriteData1,
    input  logic              RegWrite1,
    input  logic              Reserve,
    input  logic [ADDR_W-1:0] ReserveRegister,
    output logic              Busy1,
    output logic              Busy2,
    output logic [ADDR_W:0]   PendCount
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_next;
    logic [ADDR_W:0]   count_next;
    logic [ADDR_W:0]   pend_count;

    logic we0;
    logic we1;
    logic rsv;

    // When register 0 is hardwired, writes and reservations that target it
    // are masked here. Nothing downstream then needs to special-case them.
    always_comb begin
        we0 = RegWrite0;
        we1 = RegWrite1;
        rsv = Reserve;
        if (ZERO_REG != 0) begin
            if (WriteRegister0 == '0)  we0 = 1'b0;
            if (WriteRegister1 == '0)  we1 = 1'b0;
            if (ReserveRegister == '0) rsv = 1'b0;
        end
    end

    // Data storage. Port 1 is assigned last, so it wins a same-address write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (we0) regs[WriteRegister0] <= WriteData0;
            if (we1) regs[WriteRegister1] <= WriteData1;
        end
    end

    // Writeback clears a bit and issue sets one. The set is applied last,
    // because a new producer supersedes the one being retired.
    always_comb begin
        pending_next = pending;
        if (we0) pending_next[WriteRegister0] = 1'b0;
        if (we1) pending_next[WriteRegister1] = 1'b0;
        if (rsv) pending_next[ReserveRegister] = 1'b1;
    end

    always_comb begin
        count_next = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            count_next = count_next + {{ADDR_W{1'b0}}, pending_next[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending    <= '0;
            pend_count <= '0;
        end else begin
            pending    <= pending_next;
            pend_count <= count_next;
        end
    end

    assign PendCount = pend_count;

    // Read port 1. The zero register takes priority over bypass, and
    // bypass takes priority over stored data.
    always_comb begin
        ReadData1 = regs[ReadRegister1];
        Busy1     = pending[ReadRegister1];
        if (BYPASS != 0) begin
            if (we0 && WriteRegister0 == ReadRegister1) begin
                ReadData1 = WriteData0;
                Busy1     = 1'b0;
            end
            if (we1 && WriteRegister1 == ReadRegister1) begin
                ReadData1 = WriteData1;
                Busy1     = 1'b0;
            end
        end
        if (ZERO_REG != 0 && ReadRegister1 == '0) begin
            ReadData1 = '0;
            Busy1     = 1'b0;
        end
    end

    // Read port 2 uses the same priority as read port 1.
    always_comb begin
        ReadData2 = regs[ReadRegister2];
        Busy2     = pending[ReadRegister2];
        if (BYPASS != 0) begin
            if (we0 && WriteRegister0 == ReadRegister2) begin
                ReadData2 = WriteData0;
                Busy2     = 1'b0;
            end
            if (we1 && WriteRegister1 == ReadRegister2) begin
                ReadData2 = WriteData1;
                Busy2     = 1'b0;
            end
        end
        if (ZERO_REG != 0 && ReadRegister2 == '0) begin
            ReadData2 = '0;
            Busy2     = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Testbench for regfile_mp_sb. It drives a BYPASS=1 and a BYPASS=0 instance
// from the same stimulus. A reference model is checked on every cycle,
// and directed literal expectations pin the model itself.
module tb_regfile_mp_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rr1, rr2, wr0, wr1, resr;
    logic [31:0] wd0, wd1;
    logic        we0, we1, res;

    logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
    logic        b1, b2, nb_b1, nb_b2;
    logic [5:0]  pc, nb_pc;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .ReadRegister1(rr1), .ReadRegister2(rr2),
        .ReadData1(rd1), .ReadData2(rd2),
        .WriteRegister0(wr0), .WriteData0(wd0), .RegWrite0(we0),
        .WriteRegister1(wr1), .WriteData1(wd1), .RegWrite1(we1),
        .Reserve(res), .ReserveRegister(resr),
        .Busy1(b1), .Busy2(b2), .PendCount(pc)
    );

    regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n),
        .ReadRegister1(rr1), .ReadRegister2(rr2),
        .ReadData1(nb_rd1), .ReadData2(nb_rd2),
        .WriteRegister0(wr0), .WriteData0(wd0), .RegWrite0(we0),
        .WriteRegister1(wr1), .WriteData1(wd1), .RegWrite1(we1),
        .Reserve(res), .ReserveRegister(resr),
        .Busy1(nb_b1), .Busy2(nb_b2), .PendCount(nb_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural contents plus the set of pending registers.
    logic [31:0] m_reg [32];
    bit          m_pend [32];

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i]  <= '0;
                m_pend[i] <= 1'b0;
            end
        end else begin
            if (we0 && wr0 != 0) begin
                m_reg[wr0]  <= wd0;
                m_pend[wr0] <= 1'b0;
            end
            if (we1 && wr1 != 0) begin
                m_reg[wr1]  <= wd1;
                m_pend[wr1] <= 1'b0;
            end
            if (res && resr != 0) m_pend[resr] <= 1'b1;
        end
    end

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && we1 && wr1 == a) return wd1;
        if (byp && we0 && wr0 == a) return wd0;
        return m_reg[a];
    endfunction

    function automatic logic [31:0] m_busy(input logic [4:0] a, input bit byp);
        if (a == 0) return 0;
        if (byp && ((we0 && wr0 == a) || (we1 && wr1 == a))) return 0;
        return {31'b0, m_pend[a]};
    endfunction

    function automatic logic [31:0] m_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_rd1",    rd1,               m_read(rr1, 1'b1));
            chk("cyc_rd2",    rd2,               m_read(rr2, 1'b1));
            chk("cyc_b1",     {31'b0, b1},       m_busy(rr1, 1'b1));
            chk("cyc_b2",     {31'b0, b2},       m_busy(rr2, 1'b1));
            chk("cyc_pc",     {26'b0, pc},       m_count());
            chk("cyc_nb_rd1", nb_rd1,            m_read(rr1, 1'b0));
            chk("cyc_nb_rd2", nb_rd2,            m_read(rr2, 1'b0));
            chk("cyc_nb_b1",  {31'b0, nb_b1},    m_busy(rr1, 1'b0));
            chk("cyc_nb_b2",  {31'b0, nb_b2},    m_busy(rr2, 1'b0));
            chk("cyc_nb_pc",  {26'b0, nb_pc},    m_count());
        end
    end

    task automatic idle();
        we0 = 1'b0; wr0 = '0; wd0 = '0;
        we1 = 1'b0; wr1 = '0; wd1 = '0;
        res = 1'b0; resr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rr1 = '0; rr2 = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Preload r5 and mark it pending, then reset over it.
        we0 = 1'b1; wr0 = 5'd5; wd0 = 32'h1234;
        tick(); idle();
        res = 1'b1; resr = 5'd5;
        tick(); idle();
        rr1 = 5'd5; #1;
        chk("pre_rd1", rd1, 32'h1234);
        chk("pre_b1", {31'b0, b1}, 32'd1);
        chk("pre_pc", {26'b0, pc}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; #1;
        chk("rst_rd1", rd1, 32'h0);
        chk("rst_b1", {31'b0, b1}, 32'd0);
        chk("rst_pc", {26'b0, pc}, 32'd0);

        // Basic write/read, and a write to r0 that must be dropped.
        we0 = 1'b1; wr0 = 5'd3; wd0 = 32'hDEADBEEF;
        tick(); idle();
        rr2 = 5'd3; #1;
        chk("wr_rd2", rd2, 32'hDEADBEEF);
        we0 = 1'b1; wr0 = 5'd0; wd0 = 32'h55;
        tick(); idle();
        rr1 = 5'd0; #1;
        chk("r0_rd1", rd1, 32'h0);
        chk("r0_nb_rd1", nb_rd1, 32'h0);

        // Both write ports target r7 in one cycle. Port 1 must win.
        we0 = 1'b1; wr0 = 5'd7; wd0 = 32'h11;
        we1 = 1'b1; wr1 = 5'd7; wd1 = 32'h22;
        rr1 = 5'd7; #1;
        chk("dual_byp", rd1, 32'h22);
        chk("dual_nobyp", nb_rd1, 32'h0);
        tick(); idle(); #1;
        chk("dual_rd1", rd1, 32'h22);
        chk("dual_nb_rd1", nb_rd1, 32'h22);

        // Reserve r9, then write it back through port 1 with bypass.
        res = 1'b1; resr = 5'd9; rr1 = 5'd9; #1;
        chk("rsv_b1_pre", {31'b0, b1}, 32'd0);
        tick(); idle(); #1;
        chk("rsv_b1", {31'b0, b1}, 32'd1);
        chk("rsv_pc", {26'b0, pc}, 32'd1);
        we1 = 1'b1; wr1 = 5'd9; wd1 = 32'hA5; #1;
        chk("wb_rd1", rd1, 32'hA5);
        chk("wb_b1", {31'b0, b1}, 32'd0);
        chk("wb_nb_rd1", nb_rd1, 32'h0);
        chk("wb_nb_b1", {31'b0, nb_b1}, 32'd1);
        tick(); idle(); #1;
        chk("wb_pc", {26'b0, pc}, 32'd0);

        // Reserve and write the same pending register: it stays pending.
        res = 1'b1; resr = 5'd12;
        tick(); idle();
        res = 1'b1; resr = 5'd12; we0 = 1'b1; wr0 = 5'd12; wd0 = 32'h99;
        tick(); idle();
        rr1 = 5'd12; #1;
        chk("rw_pc", {26'b0, pc}, 32'd1);
        chk("rw_b1", {31'b0, b1}, 32'd1);
        chk("rw_rd1", rd1, 32'h99);
        // Reserve r4 while retiring pending r6: the count is net unchanged.
        res = 1'b1; resr = 5'd6;
        tick(); idle(); #1;
        chk("r6_pc", {26'b0, pc}, 32'd2);
        res = 1'b1; resr = 5'd4; we1 = 1'b1; wr1 = 5'd6; wd1 = 32'h66;
        tick(); idle();
        rr1 = 5'd4; rr2 = 5'd6; #1;
        chk("net_pc", {26'b0, pc}, 32'd2);
        chk("net_b1", {31'b0, b1}, 32'd1);
        chk("net_b2", {31'b0, b2}, 32'd0);
        chk("net_rd2", rd2, 32'h66);

        // Without bypass, a same-cycle write is invisible until the edge.
        res = 1'b1; resr = 5'd2;
        tick(); idle();
        we0 = 1'b1; wr0 = 5'd2; wd0 = 32'h77; rr1 = 5'd2; #1;
        chk("nb_old_rd1", nb_rd1, 32'h0);
        chk("nb_old_b1", {31'b0, nb_b1}, 32'd1);
        chk("byp_rd1", rd1, 32'h77);
        chk("byp_b1", {31'b0, b1}, 32'd0);
        tick(); idle(); #1;
        chk("nb_new_rd1", nb_rd1, 32'h77);
        chk("nb_new_b1", {31'b0, nb_b1}, 32'd0);
        chk("nb_pc", {26'b0, nb_pc}, 32'd2);

        // Two clears on one edge drop the count by two.
        we0 = 1'b1; wr0 = 5'd4;  wd0 = 32'h44;
        we1 = 1'b1; wr1 = 5'd12; wd1 = 32'hCC;
        tick(); idle(); #1;
        chk("dbl_clr_pc", {26'b0, pc}, 32'd0);

        // A reservation of r0 is ignored.
        res = 1'b1; resr = 5'd0; rr1 = 5'd0;
        tick(); idle(); #1;
        chk("r0_rsv_pc", {26'b0, pc}, 32'd0);
        chk("r0_rsv_b1", {31'b0, b1}, 32'd0);

        // Mixed traffic sweep. The per-cycle compare checks every cycle.
        for (int i = 1; i < 32; i++) begin
            idle();
            if (i % 2 == 1) begin
                we1 = 1'b1; wr1 = 5'(i); wd1 = 32'(i) * 32'h01010101 + 32'd5;
            end else begin
                we0 = 1'b1; wr0 = 5'(i); wd0 = 32'(i) * 32'h01010101 + 32'd5;
            end
            res  = 1'b1;
            resr = 5'((i * 7) % 32);
            rr1  = 5'(i);
            rr2  = 5'((i + 3) % 32);
            tick();
        end
        idle();
        tick();
        @(negedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port register file for the pipelined MIPS datapath; successor to the single-write 32x32 register file.
- Provides two combinational read ports with same-cycle write-through bypass and two synchronous write ports.
- Includes a pending-write scoreboard: issue reserves a destination, writeback releases it, and per-read-port busy flags drive the hazard/stall unit.
- Register 0 is optionally hardwired to zero.

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and reservations; 0 = register 0 is ordinary
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
ReadRegister1  in  ADDR_W  read port 1 address
ReadRegister2  in  ADDR_W  read port 2 address
ReadData1  out  DATA_W  read port 1 data (combinational)
ReadData2  out  DATA_W  read port 2 data (combinational)
WriteRegister0  in  ADDR_W  write port 0 address
WriteData0  in  DATA_W  write port 0 data
RegWrite0  in  1  write port 0 enable
WriteRegister1  in  ADDR_W  write port 1 address
WriteData1  in  DATA_W  write port 1 data
RegWrite1  in  1  write port 1 enable
Reserve  in  1  mark ReserveRegister pending (issue of a producer)
ReserveRegister  in  ADDR_W  destination being reserved
Busy1  out  1  ReadRegister1 has a pending, not-yet-available write
Busy2  out  1  ReadRegister2 has a pending, not-yet-available write
PendCount  out  ADDR_W+1  number of pending bits set

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset (rst_n=0 at a rising edge): all registers <= 0, all pending bits <= 0, PendCount <= 0. Reset overrides writes and reservations in the same cycle. Read outputs follow reset contents combinationally afterwards.
- Write: on a rising edge with RegWriteN=1, Registers[WriteRegisterN] <= WriteDataN.
  - Both ports enabled to the same address: port 1 wins.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Read (combinational, zero latency): ReadDataK = Registers[ReadRegisterK], with these overrides:
  - ZERO_REG=1 and address 0 -> 0. This takes priority over bypass.
  - BYPASS=1 and an enabled write port targets the read address this cycle -> that port's WriteData, port 1 over port 0.
- Scoreboard, one pending bit per register, updated on the rising edge:
  - An enabled write to address A clears pending[A].
  - Reserve=1 sets pending[ReserveRegister].
  - Reserve and a write to the same address in the same cycle: set wins, because a new producer supersedes the old one.
  - Reserve of an already-pending register leaves it set.
  - With ZERO_REG=1, reservations of address 0 are ignored and pending[0] stays 0.
- BusyK = pending[ReadRegisterK], except:
  - BusyK = 0 when BYPASS=1 and an enabled write targets ReadRegisterK this cycle, because the data is forwarded.
  - BusyK = 0 for address 0 when ZERO_REG=1.
- PendCount: registered population count of pending bits; it is updated in the same edge as the bits.
  - Range 0..2**ADDR_W, with no wrap because the width is ADDR_W+1.
  - Net change per edge is in {-2,-1,0,+1}. Clearing and setting bits that are already cleared or already set does not change the count.
- Writes without a prior reservation are legal: data is stored and the pending bit stays 0.
- No X propagation: every output is defined from the first reset onward.

Test Plan:
- Reset: preload r5=0x1234 and pending[5]=1, pulse rst_n=0 for one edge -> ReadData1(addr 5)=0, Busy1=0, PendCount=0.
- Basic write/read: RegWrite0=1, WriteRegister0=3, WriteData0=0xDEADBEEF for one edge, then ReadRegister2=3 -> ReadData2=0xDEADBEEF. Write 0x55 to r0 -> ReadData1(0)=0 (ZERO_REG=1).
- Dual write conflict: same edge, port0 writes r7=0x11 and port1 writes r7=0x22 -> r7=0x22.
  - Same cycle with BYPASS=1 and ReadRegister1=7 -> ReadData1=0x22 before the edge.
- Scoreboard: Reserve r9 -> Busy1(9)=1, PendCount=1.
  - Next cycle, RegWrite1 to r9=0xA5 -> Busy1=0 and ReadData1=0xA5 in that cycle (bypass); after the edge PendCount=0.
- Simultaneous reserve and write r12 with pending[12]=1 -> pending[12] stays 1, PendCount unchanged.
  - Reserve r4 plus a write to pending r6 -> PendCount unchanged net.
- BYPASS=0 build: write r2=0x77 with ReadRegister1=2 in the same cycle -> ReadData1 shows the old value and Busy1 reflects pending[2]; after the edge ReadData1=0x77.
